// File: rtl/prog_clock_divider.sv
// Bank of NUM_CH programmable integer clock dividers.
// Each channel emits a one-cycle tick every D cycles and a square wave of period 2*D.
module prog_clock_divider #(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = 21,
    parameter int DEFAULT_DIV = 1,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clock_2MHz,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    enable,
    input  logic                 sync,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [DIV_WIDTH-1:0] wr_div,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    square
);

    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] div_q [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_q [NUM_CH];
    logic [NUM_CH-1:0]    wr_hit;
    logic [NUM_CH-1:0]    at_end;
    logic [NUM_CH-1:0]    run;

    // Out-of-range channel indices match no channel, so the write is dropped.
    always_comb begin
        wr_hit = '0;
        at_end = '0;
        run    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = wr_en && (int'(wr_ch) == i);
            at_end[i] = (cnt_q[i] == div_q[i] - ONE);
            run[i]    = enable[i] && (div_q[i] != '0);
        end
    end

    always_ff @(posedge clock_2MHz) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                div_q[i]  <= DIV_RST;
                cnt_q[i]  <= '0;
                tick[i]   <= 1'b0;
                square[i] <= 1'b0;
            end else if (sync) begin
                cnt_q[i]  <= '0;
                tick[i]   <= 1'b0;
                square[i] <= 1'b0;
                if (wr_hit[i]) begin
                    div_q[i] <= wr_div;
                end
            end else if (wr_hit[i]) begin
                // Clearing cnt on every divisor change keeps cnt below div.
                div_q[i] <= wr_div;
                cnt_q[i] <= '0;
                tick[i]  <= 1'b0;
            end else if (run[i]) begin
                if (at_end[i]) begin
                    cnt_q[i]  <= '0;
                    tick[i]   <= 1'b1;
                    square[i] <= ~square[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + ONE;
                    tick[i]  <= 1'b0;
                end
            end else begin
                tick[i] <= 1'b0;
            end
        end
    end

endmodule
